// File: rtl/pp_pkg.sv
// Shared definitions for the PP input conditioner: debounce state encoding and default timing.
package pp_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 3;

    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'd0,
        DB_WAIT_HI   = 2'd1,
        DB_STABLE_HI = 2'd2,
        DB_WAIT_LO   = 2'd3
    } db_state_t;

    function automatic logic db_is_stable(input db_state_t st);
        return (st == DB_STABLE_LO) || (st == DB_STABLE_HI);
    endfunction

endpackage

// File: rtl/pp_input_conditioner_ch.sv
// One debounce channel: two-flop synchroniser, 4-state confirm FSM and confirm counter.
//   state        | meaning
//   DB_STABLE_LO | level 0 settled, watching for s=1
//   DB_WAIT_HI   | s=1 seen, counting confirm cycles before level goes 1
//   DB_STABLE_HI | level 1 settled, watching for s=0
//   DB_WAIT_LO   | s=0 seen, counting confirm cycles before level goes 0
module pp_input_conditioner_ch
    import pp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            state <= DB_STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= raw;
            s     <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Any reversal while waiting drops back to the settled state; cnt is cleared on the next entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            DB_STABLE_LO: begin
                if (s) begin
                    state_nxt = DB_WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            DB_WAIT_HI: begin
                if (!s) begin
                    state_nxt = DB_STABLE_LO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_STABLE_HI;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DB_STABLE_HI: begin
                if (!s) begin
                    state_nxt = DB_WAIT_LO;
                    cnt_nxt   = '0;
                end
            end
            DB_WAIT_LO: begin
                if (s) begin
                    state_nxt = DB_STABLE_HI;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_STABLE_LO;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DB_STABLE_LO;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    assign stable = db_is_stable(state);

endmodule

// File: rtl/pp_input_conditioner.sv
// Two independent debounced channels feeding the PP sequence FSM, plus a both-settled flag.
module pp_input_conditioner
    import pp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic ab_stable
);

    logic a_stable;
    logic b_stable;

    pp_input_conditioner_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_a (
        .Clk    (Clk),
        .Rst    (Rst),
        .raw    (a_raw),
        .level  (a),
        .rise   (a_rise),
        .fall   (a_fall),
        .stable (a_stable)
    );

    pp_input_conditioner_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch_b (
        .Clk    (Clk),
        .Rst    (Rst),
        .raw    (b_raw),
        .level  (b),
        .rise   (b_rise),
        .fall   (b_fall),
        .stable (b_stable)
    );

    assign ab_stable = a_stable & b_stable;

endmodule
